// File: rtl/parking_pkg.sv
// Shared definitions for the parking spot allocator: default sizing, FSM encoding
// and the one-hot check used to validate exit requests.
package parking_pkg;

    localparam int N_SPOTS_DEF = 8;
    localparam int IDX_W_DEF   = 3;
    localparam int MAX_SPOTS   = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Callers zero-extend their vector to MAX_SPOTS bits before the call.
    function automatic logic is_onehot(input logic [MAX_SPOTS-1:0] v);
        return (v != '0) && ((v & (v - MAX_SPOTS'(1))) == '0);
    endfunction

endpackage

// File: rtl/parking_spot_allocator_if.sv
// Handshake and status bundle between the gate/sensor controller (master)
// and the spot allocator (slave).
interface parking_spot_allocator_if #(
    parameter int N_SPOTS = 8,
    parameter int IDX_W   = 3
);
    logic               entry_req;
    logic               exit_req;
    logic [N_SPOTS-1:0] exit_location;
    logic               grant_valid;
    logic               grant_ready;
    logic [N_SPOTS-1:0] park_location;
    logic [IDX_W-1:0]   park_index;
    logic [N_SPOTS-1:0] parking_capacity;
    logic               full;
    logic               reject;
    logic               exit_err;

    modport master (
        output entry_req, exit_req, exit_location, grant_ready,
        input  grant_valid, park_location, park_index, parking_capacity,
               full, reject, exit_err
    );

    modport slave (
        input  entry_req, exit_req, exit_location, grant_ready,
        output grant_valid, park_location, park_index, parking_capacity,
               full, reject, exit_err
    );
endinterface

// File: rtl/free_spot_finder.sv
// Combinational search for the first free spot in the bitmap, starting at
// start_index and wrapping around to index 0.
module free_spot_finder #(
    parameter int N_SPOTS = 8,
    parameter int IDX_W   = 3
) (
    input  logic [N_SPOTS-1:0] bitmap,
    input  logic [IDX_W-1:0]   start_index,
    output logic [N_SPOTS-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    int pos;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        pos    = 0;
        for (int i = 0; i < N_SPOTS; i++) begin
            pos = (int'(start_index) + i) % N_SPOTS;
            if (!found && bitmap[pos]) begin
                found       = 1'b1;
                index       = IDX_W'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_spot_allocator.sv
// Free-spot bitmap owner: grants spots to entering cars over a valid/ready
// handshake and releases spots for exiting cars. ROUND_ROBIN_EN selects a
// rotating search start instead of lowest-index-first.
module parking_spot_allocator
    import parking_pkg::*;
#(
    parameter int N_SPOTS = N_SPOTS_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    parking_spot_allocator_if.slave  bus
);

    state_t             state_q, state_d;
    logic [N_SPOTS-1:0] cap_q, cap_d;
    logic [N_SPOTS-1:0] loc_q, loc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gv_q, gv_d;
    logic               reject_q, reject_d;
    logic               exit_err_q, exit_err_d;

    logic [N_SPOTS-1:0] f_onehot;
    logic [IDX_W-1:0]   f_index;
    logic               f_found;
    logic [IDX_W-1:0]   start_index;

    logic               exit_ok;
    logic [N_SPOTS-1:0] exit_mask;
    logic               handshake;

    assign exit_ok   = bus.exit_req
                     && is_onehot(MAX_SPOTS'(bus.exit_location))
                     && ((bus.exit_location & cap_q) == '0);
    assign exit_mask = exit_ok ? bus.exit_location : '0;
    assign handshake = (state_q == GRANT) && bus.grant_ready;

`ifdef ROUND_ROBIN_EN
    // rr_primed keeps the very first search at index 0 after reset.
    logic [IDX_W-1:0] last_index_q;
    logic             rr_primed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_index_q <= '0;
            rr_primed_q  <= 1'b0;
        end else if (handshake) begin
            last_index_q <= idx_q;
            rr_primed_q  <= 1'b1;
        end
    end

    always_comb begin
        start_index = '0;
        if (rr_primed_q)
            start_index = (int'(last_index_q) == N_SPOTS - 1) ? '0 : last_index_q + IDX_W'(1);
    end
`else
    assign start_index = '0;
`endif

    free_spot_finder #(
        .N_SPOTS (N_SPOTS),
        .IDX_W   (IDX_W)
    ) u_finder (
        .bitmap      (cap_q),
        .start_index (start_index),
        .onehot      (f_onehot),
        .index       (f_index),
        .found       (f_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cap_q      <= '1;
            loc_q      <= '0;
            idx_q      <= '0;
            gv_q       <= 1'b0;
            reject_q   <= 1'b0;
            exit_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            loc_q      <= loc_d;
            idx_q      <= idx_d;
            gv_q       <= gv_d;
            reject_q   <= reject_d;
            exit_err_q <= exit_err_d;
        end
    end

    // Allocation looks at the pre-exit bitmap; exits land on the same edge.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q ^ exit_mask;
        loc_d      = loc_q;
        idx_d      = idx_q;
        gv_d       = gv_q;
        reject_d   = 1'b0;
        exit_err_d = bus.exit_req && !exit_ok;
        case (state_q)
            IDLE: begin
                if (bus.entry_req) begin
                    if (f_found) begin
                        loc_d   = f_onehot;
                        idx_d   = f_index;
                        gv_d    = 1'b1;
                        state_d = GRANT;
                    end else begin
                        reject_d = !reject_q;
                    end
                end
            end
            GRANT: begin
                if (bus.grant_ready) begin
                    cap_d   = cap_q ^ loc_q ^ exit_mask;
                    gv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant_valid      = gv_q;
    assign bus.park_location    = loc_q;
    assign bus.park_index       = idx_q;
    assign bus.parking_capacity = cap_q;
    assign bus.full             = (cap_q == '0);
    assign bus.reject           = reject_q;
    assign bus.exit_err         = exit_err_q;

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Directed vector bench for parking_spot_allocator: a table of per-cycle
// stimulus with expected outputs, plus an asynchronous mid-grant reset sequence.
module tb_parking_spot_allocator;

    logic clk;
    logic reset;

    parking_spot_allocator_if #(.N_SPOTS(8), .IDX_W(3)) bus_if ();

    parking_spot_allocator #(.N_SPOTS(8), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       entry;
        logic       exit_req;
        logic [7:0] exit_loc;
        logic       ready;
        logic       gv;
        logic [7:0] loc;
        logic [2:0] idx;
        logic [7:0] cap;
        logic       reject;
        logic       exit_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic e, input logic x, input logic [7:0] xl,
                                input logic r, input logic gv, input logic [7:0] loc,
                                input logic [2:0] idx, input logic [7:0] cap,
                                input logic rej, input logic xe);
        vec_t v;
        v.entry = e; v.exit_req = x; v.exit_loc = xl; v.ready = r;
        v.gv = gv; v.loc = loc; v.idx = idx; v.cap = cap; v.reject = rej; v.exit_err = xe;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic gv, input logic [7:0] loc,
                             input logic [2:0] idx, input logic [7:0] cap,
                             input logic rej, input logic xe);
        check("grant_valid", step, 32'(bus_if.grant_valid), 32'(gv));
        check("park_location", step, 32'(bus_if.park_location), 32'(loc));
        check("park_index", step, 32'(bus_if.park_index), 32'(idx));
        check("capacity", step, 32'(bus_if.parking_capacity), 32'(cap));
        check("full", step, 32'(bus_if.full), 32'(cap == 8'h00));
        check("reject", step, 32'(bus_if.reject), 32'(rej));
        check("exit_err", step, 32'(bus_if.exit_err), 32'(xe));
    endtask

    task automatic drive(input logic e, input logic x, input logic [7:0] xl, input logic r);
        bus_if.entry_req     = e;
        bus_if.exit_req      = x;
        bus_if.exit_location = xl;
        bus_if.grant_ready   = r;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all(-1, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0);

`ifdef ROUND_ROBIN_EN
        add(1,0,8'h00,0, 1,8'h01,3'd0,8'hFF, 0,0);
        add(1,0,8'h00,1, 0,8'h01,3'd0,8'hFE, 0,0);
        add(1,0,8'h00,0, 1,8'h02,3'd1,8'hFE, 0,0);
        add(0,0,8'h00,1, 0,8'h02,3'd1,8'hFC, 0,0);
        add(0,1,8'h01,0, 0,8'h02,3'd1,8'hFD, 0,0);
        add(1,0,8'h00,0, 1,8'h04,3'd2,8'hFD, 0,0);
        add(0,0,8'h00,1, 0,8'h04,3'd2,8'hF9, 0,0);
`else
        // Fill the lot lowest-first, one grant per two cycles.
        for (int k = 0; k < 8; k++) begin
            add(1,0,8'h00,0, 1,8'(8'h01 << k),3'(k),8'(8'hFF << k), 0,0);
            add(1,0,8'h00,1, 0,8'(8'h01 << k),3'(k),8'(8'hFF << (k+1)), 0,0);
        end
        // Full lot: reject every other cycle, then a same-cycle exit still rejects.
        add(1,0,8'h00,0, 0,8'h80,3'd7,8'h00, 1,0);
        add(1,0,8'h00,0, 0,8'h80,3'd7,8'h00, 0,0);
        add(1,0,8'h00,0, 0,8'h80,3'd7,8'h00, 1,0);
        add(1,1,8'h10,0, 0,8'h80,3'd7,8'h10, 0,0);
        add(1,0,8'h00,0, 1,8'h10,3'd4,8'h10, 0,0);
        add(0,0,8'h00,1, 0,8'h10,3'd4,8'h00, 0,0);
        // Bring capacity to F0, then illegal exits.
        add(0,1,8'h10,0, 0,8'h10,3'd4,8'h10, 0,0);
        add(0,1,8'h20,0, 0,8'h10,3'd4,8'h30, 0,0);
        add(0,1,8'h40,0, 0,8'h10,3'd4,8'h70, 0,0);
        add(0,1,8'h80,0, 0,8'h10,3'd4,8'hF0, 0,0);
        add(0,1,8'h20,0, 0,8'h10,3'd4,8'hF0, 0,1);
        add(0,1,8'h03,0, 0,8'h10,3'd4,8'hF0, 0,1);
        add(0,1,8'h00,0, 0,8'h10,3'd4,8'hF0, 0,1);
        add(0,0,8'h00,0, 0,8'h10,3'd4,8'hF0, 0,0);
        // Occupy 4..7, free 0..3 to reach 0F.
        for (int k = 4; k < 8; k++) begin
            add(1,0,8'h00,0, 1,8'(8'h01 << k),3'(k),8'(8'hFF << k), 0,0);
            add(1,0,8'h00,1, 0,8'(8'h01 << k),3'(k),8'(8'hFF << (k+1)), 0,0);
        end
        add(0,1,8'h01,0, 0,8'h80,3'd7,8'h01, 0,0);
        add(0,1,8'h02,0, 0,8'h80,3'd7,8'h03, 0,0);
        add(0,1,8'h04,0, 0,8'h80,3'd7,8'h07, 0,0);
        add(0,1,8'h08,0, 0,8'h80,3'd7,8'h0F, 0,0);
        // Grant on 01 held five cycles; exit of the granted spot is illegal.
        add(1,0,8'h00,0, 1,8'h01,3'd0,8'h0F, 0,0);
        add(0,0,8'h00,0, 1,8'h01,3'd0,8'h0F, 0,0);
        add(0,0,8'h00,0, 1,8'h01,3'd0,8'h0F, 0,0);
        add(0,1,8'h01,0, 1,8'h01,3'd0,8'h0F, 0,1);
        add(0,0,8'h00,0, 1,8'h01,3'd0,8'h0F, 0,0);
        add(0,0,8'h00,0, 1,8'h01,3'd0,8'h0F, 0,0);
        add(0,1,8'h80,1, 0,8'h01,3'd0,8'h8E, 0,0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].entry, vecs[i].exit_req, vecs[i].exit_loc, vecs[i].ready);
            @(posedge clk);
            #1;
            check_all(i, vecs[i].gv, vecs[i].loc, vecs[i].idx, vecs[i].cap,
                      vecs[i].reject, vecs[i].exit_err);
        end

        // Asynchronous reset while a grant is pending.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_gv", 1000, 32'(bus_if.grant_valid), 32'(1));
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_all(1001, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_all(1002, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
